// File: rtl/varredura_display.sv
// Time-multiplexed scanner for an N_DIG-digit 7-segment display.
// Presents one nibble plus a one-hot digit enable per slot; new values are latched at frame boundaries.
module varredura_display #(
  parameter int unsigned N_DIG = 4,
  parameter int unsigned DIV   = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] VALOR,
  input  logic               LOAD,
  input  logic               BLANK_ZEROS,
  output logic [3:0]         BCD,
  output logic [N_DIG-1:0]   AN,
  output logic               ACK,
  output logic               FRAME
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(N_DIG);
  localparam logic [PW-1:0] PrescMax = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxMax   = IW'(N_DIG - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] disp_q, disp_d;
  logic [4*N_DIG-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic [3:0]         bcd_q, bcd_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic               ack_q, ack_d;
  logic               frame_q;
  logic               tick;
  logic               boundary;
  logic [N_DIG-1:0]   blank_mask;
  logic               run_zero;

  always_comb begin
    tick     = (presc_q == PrescMax);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
    boundary = tick && (idx_q == IdxMax);
  end

  // A LOAD coinciding with the boundary bypasses pend and goes straight to disp.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    ack_d    = 1'b0;
    if (boundary) begin
      pend_v_d = 1'b0;
      ack_d    = LOAD | pend_v_q;
      if (LOAD) begin
        disp_d = VALOR;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end
    end else if (LOAD) begin
      pend_d   = VALOR;
      pend_v_d = 1'b1;
    end
  end

  // blank_mask[k] set when nibbles N_DIG-1..k of the value being shown are all zero.
  always_comb begin
    blank_mask = '0;
    run_zero   = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      run_zero      = run_zero && (disp_d[4*k +: 4] == 4'h0);
      blank_mask[k] = run_zero;
    end
  end

  always_comb begin
    bcd_d        = disp_d[{idx_d, 2'b00} +: 4];
    an_d         = '0;
    an_d[idx_d]  = 1'b1;
    if (BLANK_ZEROS && blank_mask[idx_d]) begin
      an_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      bcd_q    <= 4'h0;
      an_q     <= N_DIG'(1);
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= ack_d;
      frame_q  <= boundary;
      if (tick) begin
        bcd_q <= bcd_d;
        an_q  <= an_d;
      end
    end
  end

  assign BCD   = bcd_q;
  assign AN    = an_q;
  assign ACK   = ack_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with N_DIG=4, DIV=4 (16-cycle frames).
module tb_varredura_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] VALOR;
  logic        LOAD;
  logic        BLANK_ZEROS;
  logic [3:0]  BCD;
  logic [3:0]  AN;
  logic        ACK;
  logic        FRAME;

  int vectors;
  int miscompares;

  varredura_display #(
    .N_DIG(4),
    .DIV  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .VALOR      (VALOR),
    .LOAD       (LOAD),
    .BLANK_ZEROS(BLANK_ZEROS),
    .BCD        (BCD),
    .AN         (AN),
    .ACK        (ACK),
    .FRAME      (FRAME)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting at the first cycle of a frame, check all 16 cycles; an_pat holds AN per digit.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [15:0] an_pat,
                             input logic exp_ack);
    for (int s = 0; s < 16; s++) begin
      int d;
      d = s / 4;
      check($sformatf("%s an s%0d", tag, s), {12'h0, AN}, {12'h0, an_pat[4*d +: 4]});
      check($sformatf("%s bcd s%0d", tag, s), {12'h0, BCD}, {12'h0, val[4*d +: 4]});
      check($sformatf("%s frame s%0d", tag, s), {15'h0, FRAME}, {15'h0, (s == 0)});
      check($sformatf("%s ack s%0d", tag, s), {15'h0, ACK}, {15'h0, (s == 0) ? exp_ack : 1'b0});
      @(negedge clk);
    end
  endtask

  // Wait (bounded) for ACK; the rejected value AAAA must never reach BCD.
  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (!ACK && n < 40) begin
      check($sformatf("%s no_a", tag), {15'h0, (BCD == 4'hA)}, 16'h0);
      @(negedge clk);
      n++;
    end
    check($sformatf("%s ack_seen", tag), {15'h0, ACK}, 16'h1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    VALOR = v;
    LOAD  = 1'b1;
    @(negedge clk);
    LOAD  = 1'b0;
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    VALOR       = 16'h0;
    LOAD        = 1'b0;
    BLANK_ZEROS = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst bcd", {12'h0, BCD}, 16'h0);
    check("rst an", {12'h0, AN}, 16'h1);
    check("rst ack", {15'h0, ACK}, 16'h0);
    check("rst frame", {15'h0, FRAME}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic scan of 1234
    pulse_load(16'h1234);
    wait_ack("t1");
    check_frame("t1a", 16'h1234, 16'h8421, 1'b1);
    check_frame("t1b", 16'h1234, 16'h8421, 1'b0);

    // 2: leading-zero blanking of 0050, then blanking off
    BLANK_ZEROS = 1'b1;
    pulse_load(16'h0050);
    wait_ack("t2");
    check_frame("t2a", 16'h0050, 16'h0021, 1'b1);
    BLANK_ZEROS = 1'b0;
    check_frame("t2b", 16'h0050, 16'h8421, 1'b0);

    // 3: zero shows a single digit
    BLANK_ZEROS = 1'b1;
    pulse_load(16'h0000);
    wait_ack("t3");
    check_frame("t3", 16'h0000, 16'h0001, 1'b1);

    // 4: two loads in one frame, only the last is shown with one ACK
    BLANK_ZEROS = 1'b0;
    pulse_load(16'hAAAA);
    @(negedge clk);
    @(negedge clk);
    pulse_load(16'h5555);
    wait_ack("t4");
    check_frame("t4a", 16'h5555, 16'h8421, 1'b1);
    check_frame("t4b", 16'h5555, 16'h8421, 1'b0);

    // 5: LOAD exactly in the boundary cycle
    for (int i = 0; i < 15; i++) @(negedge clk);
    pulse_load(16'h9876);
    check("t5 ack", {15'h0, ACK}, 16'h1);
    check("t5 frame", {15'h0, FRAME}, 16'h1);
    check("t5 bcd", {12'h0, BCD}, 16'h6);
    check("t5 an", {12'h0, AN}, 16'h1);
    check_frame("t5a", 16'h9876, 16'h8421, 1'b1);
    check_frame("t5b", 16'h9876, 16'h8421, 1'b0);

    // 6: asynchronous reset mid-frame with a load pending
    pulse_load(16'h1111);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("t6 pre an", {12'h0, AN}, 16'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst bcd", {12'h0, BCD}, 16'h0);
    check("t6 rst an", {12'h0, AN}, 16'h1);
    check("t6 rst ack", {15'h0, ACK}, 16'h0);
    check("t6 rst frame", {15'h0, FRAME}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!FRAME && n < 40) begin
      check("t6 no_ack", {15'h0, ACK}, 16'h0);
      @(negedge clk);
      n++;
    end
    check("t6 frame_seen", {15'h0, FRAME}, 16'h1);
    check_frame("t6", 16'h0000, 16'h8421, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
